// File: rtl/status_pkg.sv
// Shared definitions for the status LED fader / PWM decoder pair.
package status_pkg;

  // Matches the fader's 4-bit intensity so a looped-back line decodes 1:1.
  localparam int unsigned DEFAULT_WIN_BITS = 4;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage : status_pkg

// File: rtl/status_pwm_decoder.sv
// Windowed high-cycle counter recovering the duty level of a density-modulated
// line, with stuck-low / stuck-high detection over consecutive full windows.
module status_pwm_decoder
  import status_pkg::*;
#(
  parameter int unsigned WIN_BITS      = DEFAULT_WIN_BITS,
  parameter int unsigned STUCK_WINDOWS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_in,
  output logic [WIN_BITS-1:0] level,
  output logic                level_valid,
  output logic                stuck_low,
  output logic                stuck_high
);

  localparam int unsigned AW       = WIN_BITS + 1;
  localparam int unsigned SW       = $clog2(STUCK_WINDOWS + 1);
  localparam int unsigned WIN_LAST = (1 << WIN_BITS) - 1;
  localparam int unsigned WIN_LEN  = 1 << WIN_BITS;

  state_t              state, state_next;
  logic                flush_cnt, flush_next;
  logic                run;
  logic [1:0]          sync;
  logic                s;
  logic [WIN_BITS-1:0] wcnt;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       total;
  logic [SW-1:0]       zcnt, ocnt;
  logic [SW-1:0]       zcnt_next, ocnt_next;
  logic                win_end;
  logic                all_low, all_high;
  logic [WIN_BITS-1:0] level_sat;

  assign s = sync[1];

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FLUSH;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_next;
    end
  end

  // FLUSH lasts two cycles so the synchronizer refills before sampling
  always_comb begin
    state_next = state;
    flush_next = flush_cnt;
    run        = 1'b0;
    case (state)
      FLUSH: begin
        flush_next = 1'b1;
        if (flush_cnt) state_next = RUN;
      end
      RUN: run = 1'b1;
    endcase
  end

  // Window accounting; total includes the current sample so none is lost
  always_comb begin
    total     = acc + AW'(s);
    win_end   = run && (wcnt == WIN_BITS'(WIN_LAST));
    all_low   = (total == '0);
    all_high  = (total == AW'(WIN_LEN));
    level_sat = all_high ? WIN_BITS'(WIN_LAST) : total[WIN_BITS-1:0];
    zcnt_next = '0;
    ocnt_next = '0;
    if (all_low) begin
      zcnt_next = (zcnt == SW'(STUCK_WINDOWS)) ? zcnt : zcnt + SW'(1);
    end
    if (all_high) begin
      ocnt_next = (ocnt == SW'(STUCK_WINDOWS)) ? ocnt : ocnt + SW'(1);
    end
  end

  // Synchronizer, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync        <= '0;
      wcnt        <= '0;
      acc         <= '0;
      zcnt        <= '0;
      ocnt        <= '0;
      level       <= '0;
      level_valid <= 1'b0;
      stuck_low   <= 1'b0;
      stuck_high  <= 1'b0;
    end else begin
      sync        <= {sync[0], pwm_in};
      level_valid <= 1'b0;
      if (run) begin
        wcnt <= wcnt + WIN_BITS'(1);
        if (win_end) begin
          acc         <= '0;
          level       <= level_sat;
          level_valid <= 1'b1;
          zcnt        <= zcnt_next;
          ocnt        <= ocnt_next;
          stuck_low   <= (zcnt_next == SW'(STUCK_WINDOWS));
          stuck_high  <= (ocnt_next == SW'(STUCK_WINDOWS));
        end else begin
          acc <= total;
        end
      end
    end
  end

endmodule : status_pwm_decoder

// File: tb/tb_status_pwm_decoder.sv
// Self-checking bench for status_pwm_decoder: a per-window reference model
// pushes expected results that are popped when the strobe is due.
module tb_status_pwm_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic [3:0] level;
  logic       level_valid;
  logic       stuck_low;
  logic       stuck_high;

  status_pwm_decoder #(.WIN_BITS(4), .STUCK_WINDOWS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .level      (level),
    .level_valid(level_valid),
    .stuck_low  (stuck_low),
    .stuck_high (stuck_high)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] lvl;
    logic       sl;
    logic       sh;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ecnt;
  int   wsum;
  int   zc;
  int   oc;
  logic exp_v;

  task automatic model_clear();
    ecnt = -1;
    wsum = 0;
    zc   = 0;
    oc   = 0;
    cur  = '0;
    exp_q.delete();
  endtask

  // Window n counts pwm_in as sampled on reset-low edges 16n .. 16n+15;
  // its result is visible after edge 16n+17.
  task automatic step(input logic b);
    exp_t e;
    int   tot;
    pwm_in = b;
    @(posedge clk);
    ecnt++;
    wsum += int'(b);
    if (ecnt % 16 == 15) begin
      tot  = wsum;
      wsum = 0;
      if (tot == 0) begin
        zc = (zc < 4) ? zc + 1 : zc;
        oc = 0;
      end else if (tot == 16) begin
        oc = (oc < 4) ? oc + 1 : oc;
        zc = 0;
      end else begin
        zc = 0;
        oc = 0;
      end
      e.lvl = 4'((tot > 15) ? 15 : tot);
      e.sl  = (zc == 4);
      e.sh  = (oc == 4);
      exp_q.push_back(e);
    end
    exp_v = (ecnt >= 17) && ((ecnt - 17) % 16 == 0);
    if (exp_v && exp_q.size() > 0) cur = exp_q.pop_front();
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    pwm_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({level_valid, level, stuck_low, stuck_high} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset: got v=%b lvl=%0d sl=%b sh=%b, want all 0",
               level_valid, level, stuck_low, stuck_high);
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_constant(input logic b);
    do_reset();
    for (int i = 0; i < 6 * 16 + 2; i++) begin
      step(b);
      n_cmp++;
      if ({level_valid, level, stuck_low, stuck_high} !== {exp_v, cur.lvl, cur.sl, cur.sh}) begin
        n_bad++;
        $display("FAIL const%0b e=%0d: got v=%b lvl=%0d sl=%b sh=%b want v=%b lvl=%0d sl=%b sh=%b",
                 b, ecnt, level_valid, level, stuck_low, stuck_high, exp_v, cur.lvl, cur.sl, cur.sh);
      end
    end
    n_cmp++;
    if ({stuck_low, stuck_high, level} !== {~b, b, (b ? 4'd15 : 4'd0)}) begin
      n_bad++;
      $display("FAIL const%0b_final: got sl=%b sh=%b lvl=%0d want sl=%b sh=%b lvl=%0d",
               b, stuck_low, stuck_high, level, ~b, b, (b ? 15 : 0));
    end
  endtask

  task automatic test_encoder();
    logic [3:0] acc4;
    logic [4:0] sum;
    do_reset();
    acc4 = '0;
    for (int i = 0; i < 6 * 16 + 2; i++) begin
      sum  = {1'b0, acc4} + 5'd5;
      acc4 = sum[3:0];
      step(sum[4]);
      n_cmp++;
      if ({level_valid, level, stuck_low, stuck_high} !== {exp_v, cur.lvl, cur.sl, cur.sh}) begin
        n_bad++;
        $display("FAIL encoder e=%0d: got v=%b lvl=%0d sl=%b sh=%b want v=%b lvl=%0d sl=%b sh=%b",
                 ecnt, level_valid, level, stuck_low, stuck_high, exp_v, cur.lvl, cur.sl, cur.sh);
      end
      if (exp_v && ecnt > 17) begin
        n_cmp++;
        if (level !== 4'd5) begin
          n_bad++;
          $display("FAIL encoder_level e=%0d: got %0d want 5", ecnt, level);
        end
      end
    end
  endtask

  task automatic test_toggle_stuck();
    logic b;
    do_reset();
    for (int i = 0; i < 4 * 16 + 4 * 16 + 3 * 16 + 2; i++) begin
      b = (i < 64 || i >= 128) ? 1'(i % 2) : 1'b1;
      step(b);
      n_cmp++;
      if ({level_valid, level, stuck_low, stuck_high} !== {exp_v, cur.lvl, cur.sl, cur.sh}) begin
        n_bad++;
        $display("FAIL toggle e=%0d: got v=%b lvl=%0d sl=%b sh=%b want v=%b lvl=%0d sl=%b sh=%b",
                 ecnt, level_valid, level, stuck_low, stuck_high, exp_v, cur.lvl, cur.sl, cur.sh);
      end
      if (ecnt == 129 || ecnt == 145) begin
        n_cmp++;
        if (stuck_high !== (ecnt == 129)) begin
          n_bad++;
          $display("FAIL stuck_high_edge e=%0d: got %b want %b", ecnt, stuck_high, ecnt == 129);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 25; i++) begin
      step(1'(i % 2));
      n_cmp++;
      if ({level_valid, level, stuck_low, stuck_high} !== {exp_v, cur.lvl, cur.sl, cur.sh}) begin
        n_bad++;
        $display("FAIL pre_reset e=%0d: got v=%b lvl=%0d want v=%b lvl=%0d",
                 ecnt, level_valid, level, exp_v, cur.lvl);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({level_valid, level, stuck_low, stuck_high} !== 7'b0) begin
      n_bad++;
      $display("FAIL mid_reset_clear: got v=%b lvl=%0d sl=%b sh=%b want all 0",
               level_valid, level, stuck_low, stuck_high);
    end
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 40; i++) begin
      step(1'b1);
      n_cmp++;
      if ({level_valid, level, stuck_low, stuck_high} !== {exp_v, cur.lvl, cur.sl, cur.sh}) begin
        n_bad++;
        $display("FAIL post_reset e=%0d: got v=%b lvl=%0d want v=%b lvl=%0d",
                 ecnt, level_valid, level, exp_v, cur.lvl);
      end
    end
  endtask

  task automatic test_random();
    int thresh;
    do_reset();
    thresh = 8;
    for (int i = 0; i < 1000 * 16 + 2; i++) begin
      if (i % 16 == 0) begin
        thresh = int'($urandom_range(0, 19));
        if (thresh > 16) thresh = (thresh == 17) ? 0 : 16;
      end
      step(int'($urandom_range(0, 15)) < thresh);
      n_cmp++;
      if ({level_valid, level, stuck_low, stuck_high} !== {exp_v, cur.lvl, cur.sl, cur.sh}) begin
        n_bad++;
        $display("FAIL random e=%0d: got v=%b lvl=%0d sl=%b sh=%b want v=%b lvl=%0d sl=%b sh=%b",
                 ecnt, level_valid, level, stuck_low, stuck_high, exp_v, cur.lvl, cur.sl, cur.sh);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    exp_v  = 1'b0;
    model_clear();
    test_reset();
    test_constant(1'b0);
    test_constant(1'b1);
    test_encoder();
    test_toggle_stuck();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_status_pwm_decoder

// File: doc/status_pwm_decoder.md
# status_pwm_decoder

Recovers the duty level of a single-bit density-modulated (first-order sigma-delta / PWM) signal by counting high cycles over a fixed window. It is the receive-side counterpart of the status LED fader, which encodes a 4-bit intensity as a carry-out bit stream. Used on the test boards to loop an LED drive line back into the FPGA, and to monitor external indicator lines, with stuck-line detection.

## Interface

- WIN_BITS, 4, log2 of window length in clocks; window = 2^WIN_BITS cycles; level width
- STUCK_WINDOWS, 4, consecutive all-0 / all-1 windows before a stuck flag sets (1..255)
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- pwm_in  input  1  asynchronous density-modulated input
- level  output  WIN_BITS  high-cycle count of last completed window, saturated
- level_valid  output  1  one-cycle strobe: level updated this cycle
- stuck_low  output  1  input low for STUCK_WINDOWS consecutive full windows
- stuck_high  output  1  input high for STUCK_WINDOWS consecutive full windows

## Operation

- Input path: pwm_in → two-flop synchronizer → s. Synchronizer flops reset to 0.
- FSM states: FLUSH, RUN.
  - FLUSH: entered on reset; held exactly 2 cycles (synchronizer refill); no accumulation; → RUN.
  - RUN: permanent until reset.
- In RUN, each cycle: wcnt increments (wraps at 2^WIN_BITS−1 → 0); acc += s.
- On the cycle wcnt == 2^WIN_BITS−1 (last sample of window): total = acc + s (width WIN_BITS+1, max 2^WIN_BITS); next cycle level = min(total, 2^WIN_BITS−1), level_valid = 1; acc cleared for the new window (the new window's first sample accumulates from 0, no sample lost).
- Saturation: total 2^WIN_BITS (all-high window) reports 2^WIN_BITS−1.
- Stuck tracking, evaluated at each window end:
  - total == 0: zcnt++ (saturating at STUCK_WINDOWS), ocnt = 0.
  - total == 2^WIN_BITS: ocnt++ (saturating), zcnt = 0.
  - otherwise both cleared.
  - stuck_low = (zcnt == STUCK_WINDOWS); stuck_high = (ocnt == STUCK_WINDOWS); mutually exclusive by construction.
- Flags and level update only at window boundaries; they change on the same cycle as the level_valid strobe.

## Timing

- Reset values: level = 0, level_valid = 0, stuck_low = 0, stuck_high = 0, wcnt = 0, acc = 0, zcnt = ocnt = 0, state = FLUSH.
- Cycle 0 = first clk edge with reset low. Cycles 0–1: FLUSH. Cycle 2: first RUN sample (wcnt = 0).
- First level_valid at cycle 2 + 2^WIN_BITS (cycle 18 at default); thereafter every 2^WIN_BITS cycles, exactly one cycle wide.
- pwm_in to s latency: 2 cycles. Window n covers s in cycles 2+n·2^W … 1+(n+1)·2^W.
- Reset asserted mid-window: all state returns to reset values on that edge; partial window discarded, no strobe; restart from FLUSH.
- A stuck flag sets at the end of window STUCK_WINDOWS of a constant run and clears at the end of the first mixed or opposite window.

## Structure

- Single module; no sub-modules. Two-flop synchronizer inline.
- Shared package (status_pkg): FSM state encoding (FLUSH, RUN) and default WIN_BITS = 4 matching the LED fader's 4-bit intensity.
- Counter widths: wcnt WIN_BITS, acc WIN_BITS+1, zcnt/ocnt $clog2(STUCK_WINDOWS+1).

## Test plan

- pwm_in = 0 constant, defaults → level 0 at cycles 18, 34, 50, 66; stuck_low rises at cycle 66 with the fourth strobe; stuck_high stays 0.
- pwm_in = 1 constant → level 15 (saturated from 16) each strobe; stuck_high rises at cycle 66.
- pwm_in driven by a reference first-order encoder (5-bit acc += intensity 5, output carry) → every strobe reports level 5 (±1 on the first window only).
- pwm_in toggling every cycle → level 8 every strobe; no stuck flags; then hold 1 for 4 windows → stuck_high set, restore toggle → cleared at next strobe.
- Reset pulsed at cycle 25 (mid second window) → all outputs 0 next cycle; next level_valid exactly 18 cycles after reset deasserts.
- Check level_valid is never high two consecutive cycles and spacing is exactly 16 cycles across 1000 windows of random input; level equals the model's windowed count.
